// File: rtl/reg_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// reg_hazard_ctrl
//
// Read-port controller and write sequencer for the 16 x 16-bit register file.
// It tracks the destination registers of instructions in the EX, MEM and WB
// stages. From these it derives three things:
//   - the two read-port forward selects,
//   - a decode stall on unresolved read-after-write hazards,
//   - the register-file write strobes, taken from the WB stage.
//
// Ports:
//   i_clk                 system clock, rising edge
//   i_rst_n               asynchronous active-low reset
//   i_dec_valid           decode holds a valid instruction
//   i_use_1 / i_use_2     instruction reads i_rn_1 / i_rn_2
//   i_rn_1 / i_rn_2       source register numbers
//   i_dec_wr, i_dec_wrn   instruction writes register i_dec_wrn
//   i_dec_wr0             instruction side-writes R0 (mul high / div remainder)
//   i_flush               kill in-flight EX/MEM entries (branch taken)
//   o_reg_forward_1/2     read-port forward selects
//   o_stall               hold fetch/decode this cycle
//   o_wr, o_wrn, o_wr0    register-file write strobes from WB
//   o_stall_cnt           saturating count of stall cycles
// -----------------------------------------------------------------------------
module reg_hazard_ctrl #(
  parameter int unsigned REG_NUM_WIDTH     = 4,
  parameter int unsigned REG_FORWARD_WIDTH = 2,
  parameter int unsigned STALL_CNT_WIDTH   = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_dec_valid,
  input  logic                         i_use_1,
  input  logic                         i_use_2,
  input  logic [REG_NUM_WIDTH-1:0]     i_rn_1,
  input  logic [REG_NUM_WIDTH-1:0]     i_rn_2,
  input  logic                         i_dec_wr,
  input  logic [REG_NUM_WIDTH-1:0]     i_dec_wrn,
  input  logic                         i_dec_wr0,
  input  logic                         i_flush,
  output logic [REG_FORWARD_WIDTH-1:0] o_reg_forward_1,
  output logic [REG_FORWARD_WIDTH-1:0] o_reg_forward_2,
  output logic                         o_stall,
  output logic                         o_wr,
  output logic [REG_NUM_WIDTH-1:0]     o_wrn,
  output logic                         o_wr0,
  output logic [STALL_CNT_WIDTH-1:0]   o_stall_cnt
);

  localparam logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_REG_FILE = REG_FORWARD_WIDTH'(0);
  localparam logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_WB       = REG_FORWARD_WIDTH'(1);
  localparam logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_R0       = REG_FORWARD_WIDTH'(2);

  typedef struct packed {
    logic                     v;
    logic                     wr;
    logic [REG_NUM_WIDTH-1:0] wrn;
    logic                     wr0;
  } stage_t;

  localparam stage_t Bubble = '0;

  stage_t r_ex, r_mem, r_wb;
  stage_t w_ex_d, w_mem_d, w_wb_d;
  stage_t w_dec;

  logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;
  logic                       w_hazard_1, w_hazard_2;

  // True when stage s will write the register that rn reads (R0 also via side-write).
  function automatic logic stage_hit(input stage_t s, input logic [REG_NUM_WIDTH-1:0] rn);
    return s.v & ((s.wr & (s.wrn == rn)) | ((rn == '0) & s.wr0));
  endfunction

  // R0 side-write has priority over an R0 write through wrn.
  function automatic logic [REG_FORWARD_WIDTH-1:0] fwd_sel(input logic                     use_p,
                                                           input logic [REG_NUM_WIDTH-1:0] rn,
                                                           input stage_t                   wb);
    logic [REG_FORWARD_WIDTH-1:0] sel;
    sel = REG_FORWARD_REG_FILE;
    if (use_p) begin
      if ((rn == '0) && wb.v && wb.wr0) begin
        sel = REG_FORWARD_R0;
      end else if (wb.v && wb.wr && (wb.wrn == rn)) begin
        sel = REG_FORWARD_WB;
      end
    end
    return sel;
  endfunction

  // Hazard detection and forward selects (Mealy on decode inputs).
  always_comb begin
    w_hazard_1 = i_dec_valid & i_use_1 & (stage_hit(r_ex, i_rn_1) | stage_hit(r_mem, i_rn_1));
    w_hazard_2 = i_dec_valid & i_use_2 & (stage_hit(r_ex, i_rn_2) | stage_hit(r_mem, i_rn_2));
    // Flush discards the decode slot anyway, so stalling would only waste a cycle.
    o_stall         = (w_hazard_1 | w_hazard_2) & ~i_flush;
    o_reg_forward_1 = fwd_sel(i_use_1, i_rn_1, r_wb);
    o_reg_forward_2 = fwd_sel(i_use_2, i_rn_2, r_wb);
  end

  // Next-state for the stage entries.
  always_comb begin
    w_dec.v   = 1'b1;
    w_dec.wr  = i_dec_wr;
    w_dec.wrn = i_dec_wrn;
    w_dec.wr0 = i_dec_wr0;

    // WB always takes MEM's current value, so an older write retires through a flush.
    w_wb_d = r_mem;
    if (i_flush) begin
      w_ex_d  = Bubble;
      w_mem_d = Bubble;
    end else begin
      w_mem_d = r_ex;
      w_ex_d  = (i_dec_valid && !o_stall) ? w_dec : Bubble;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex  <= Bubble;
      r_mem <= Bubble;
      r_wb  <= Bubble;
    end else begin
      r_ex  <= w_ex_d;
      r_mem <= w_mem_d;
      r_wb  <= w_wb_d;
    end
  end

  // Saturating stall counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (o_stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_WIDTH'(1);
    end
  end

  // Write strobes come purely from the registered WB entry.
  always_comb begin
    o_wr        = r_wb.v & r_wb.wr;
    o_wrn       = r_wb.wrn;
    o_wr0       = r_wb.v & r_wb.wr0;
    o_stall_cnt = r_stall_cnt;
  end

endmodule

// File: tb/tb_reg_hazard_ctrl.sv
module tb_reg_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       dec_valid, use_1, use_2, dec_wr, dec_wr0, flush;
  logic [3:0] rn_1, rn_2, dec_wrn;
  logic [1:0] fwd_1, fwd_2;
  logic       stall, wr, wr0;
  logic [3:0] wrn;
  logic [7:0] stall_cnt;

  reg_hazard_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_dec_valid    (dec_valid),
    .i_use_1        (use_1),
    .i_use_2        (use_2),
    .i_rn_1         (rn_1),
    .i_rn_2         (rn_2),
    .i_dec_wr       (dec_wr),
    .i_dec_wrn      (dec_wrn),
    .i_dec_wr0      (dec_wr0),
    .i_flush        (flush),
    .o_reg_forward_1(fwd_1),
    .o_reg_forward_2(fwd_2),
    .o_stall        (stall),
    .o_wr           (wr),
    .o_wrn          (wrn),
    .o_wr0          (wr0),
    .o_stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dv, u1, u2, dwr, dwr0, fl;
    logic [3:0] rn1, rn2, dwrn;
    logic       st, wr, wr0;
    logic [1:0] f1, f2;
    logic [3:0] wrn;
  } vec_t;

  typedef struct {
    int         idx;
    logic       st, wr, wr0;
    logic [1:0] f1, f2;
    logic [3:0] wrn;
    logic [7:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [7:0] exp_cnt = 8'd0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Inputs: dv, use_1, rn_1, use_2, rn_2, dec_wr, dec_wrn, dec_wr0, flush.
  // Expected: stall, fwd_1, fwd_2, wr, wrn, wr0.
  task automatic add(input logic dv, u1, input logic [3:0] rn1, input logic u2,
                     input logic [3:0] rn2, input logic dwr, input logic [3:0] dwrn,
                     input logic dwr0, fl, st, input logic [1:0] f1, f2, input logic ewr,
                     input logic [3:0] ewrn, input logic ewr0);
    vec_t v;
    v.dv = dv; v.u1 = u1; v.rn1 = rn1; v.u2 = u2; v.rn2 = rn2;
    v.dwr = dwr; v.dwrn = dwrn; v.dwr0 = dwr0; v.fl = fl;
    v.st = st; v.f1 = f1; v.f2 = f2; v.wr = ewr; v.wrn = ewrn; v.wr0 = ewr0;
    vecs.push_back(v);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) add(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
  endtask

  task automatic wr_reg(input logic [3:0] r);
    add(1,0,0,0,0,1,r,0,0, 0,0,0,0,0,0);
  endtask

  task automatic indep(input int n);
    for (int k = 0; k < n; k++) add(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
  endtask

  task automatic drive_idle();
    dec_valid = 0; use_1 = 0; use_2 = 0; rn_1 = 0; rn_2 = 0;
    dec_wr = 0; dec_wrn = 0; dec_wr0 = 0; flush = 0;
  endtask

  initial begin
    exp_t e;
    bit   found;

    // Reset idle
    idle(10);
    // Distance-1 RAW on R5: two stalls, then forward from WB
    wr_reg(5);
    add(1,1,5,0,0,0,0,0,0, 1,0,0,0,0,0);
    add(1,1,5,0,0,0,0,0,0, 1,0,0,0,0,0);
    add(1,1,5,0,0,0,0,0,0, 0,1,0,1,5,0);
    idle(3);
    // Distance 2 on port 2: one stall
    wr_reg(6);
    indep(1);
    add(1,0,0,1,6,0,0,0,0, 1,0,0,0,0,0);
    add(1,0,0,1,6,0,0,0,0, 0,0,1,1,6,0);
    idle(3);
    // Distance 3 forwards without stall, distance 4 reads the file
    wr_reg(9);
    indep(2);
    add(1,1,9,0,0,0,0,0,0, 0,1,0,1,9,0);
    add(1,1,9,0,0,0,0,0,0, 0,0,0,0,0,0);
    idle(3);
    // R0 side-write forwarded on port 2
    add(1,0,0,0,0,0,0,1,0, 0,0,0,0,0,0);
    wr_reg(4);
    wr_reg(8);
    add(1,0,0,1,0,0,0,0,0, 0,0,2,0,0,1);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,1,4,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,1,8,0);
    idle(2);
    // wr to R0 and wr0 together: R0 select wins on both ports
    add(1,0,0,0,0,1,0,1,0, 0,0,0,0,0,0);
    indep(2);
    add(1,1,0,1,0,0,0,0,0, 0,2,2,1,0,1);
    idle(3);
    // wr0 in EX/MEM stalls an R0 reader; wrn passes through while wr=0
    add(1,0,0,0,0,0,3,1,0, 0,0,0,0,0,0);
    add(1,1,0,0,0,0,0,0,0, 1,0,0,0,0,0);
    add(1,1,0,0,0,0,0,0,0, 1,0,0,0,0,0);
    add(1,1,0,0,0,0,0,0,0, 0,2,0,0,3,1);
    idle(3);
    // Dual-port hazard R2/R7
    wr_reg(2);
    wr_reg(7);
    add(1,1,2,1,7,0,0,0,0, 1,0,0,0,0,0);
    add(1,1,2,1,7,0,0,0,0, 1,1,0,1,2,0);
    add(1,1,2,1,7,0,0,0,0, 0,0,1,1,7,0);
    idle(3);
    // Flush kills R3 in EX; R1 already in MEM retires
    wr_reg(1);
    wr_reg(3);
    add(0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0);
    add(1,1,3,1,1,0,0,0,0, 0,0,1,1,1,0);
    idle(3);
    // Flush and hazard together: no stall, no count
    wr_reg(4);
    add(1,1,4,0,0,0,0,0,1, 0,0,0,0,0,0);
    add(1,1,4,0,0,0,0,0,0, 0,0,0,0,0,0);
    idle(1);
    // No hazard without dec_valid; no forward without use
    wr_reg(5);
    add(0,1,5,0,0,0,0,0,0, 0,0,0,0,0,0);
    idle(1);
    add(1,0,5,0,0,0,0,0,0, 0,0,0,1,5,0);
    idle(1);

    drive_idle();
    rst_n = 1'b0;
    #12;
    chk("reset_async_stall", {7'd0, stall}, 8'd0);
    chk("reset_async_wr", {7'd0, wr}, 8'd0);
    chk("reset_async_cnt", stall_cnt, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      dec_valid = vecs[i].dv; use_1 = vecs[i].u1; rn_1 = vecs[i].rn1;
      use_2 = vecs[i].u2; rn_2 = vecs[i].rn2; dec_wr = vecs[i].dwr;
      dec_wrn = vecs[i].dwrn; dec_wr0 = vecs[i].dwr0; flush = vecs[i].fl;
      e.idx = i; e.st = vecs[i].st; e.f1 = vecs[i].f1; e.f2 = vecs[i].f2;
      e.wr = vecs[i].wr; e.wrn = vecs[i].wrn; e.wr0 = vecs[i].wr0; e.cnt = exp_cnt;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d_stall", e.idx), {7'd0, stall}, {7'd0, e.st});
      chk($sformatf("v%0d_fwd1", e.idx), {6'd0, fwd_1}, {6'd0, e.f1});
      chk($sformatf("v%0d_fwd2", e.idx), {6'd0, fwd_2}, {6'd0, e.f2});
      chk($sformatf("v%0d_wr", e.idx), {7'd0, wr}, {7'd0, e.wr});
      chk($sformatf("v%0d_wrn", e.idx), {4'd0, wrn}, {4'd0, e.wrn});
      chk($sformatf("v%0d_wr0", e.idx), {7'd0, wr0}, {7'd0, e.wr0});
      chk($sformatf("v%0d_cnt", e.idx), stall_cnt, e.cnt);
      if (e.st && exp_cnt != 8'hFF) exp_cnt++;
      @(posedge clk);
      #1;
    end

    // Saturation: a self-dependent R5 writer stalls 2 of every 3 cycles
    drive_idle();
    dec_valid = 1; use_1 = 1; rn_1 = 5; dec_wr = 1; dec_wrn = 5;
    repeat (460) @(posedge clk);
    @(negedge clk);
    chk("sat_cnt", stall_cnt, 8'hFF);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("sat_hold", stall_cnt, 8'hFF);

    // Async reset while a write is in WB
    found = 0;
    for (int k = 0; k < 6 && !found; k++) begin
      if (wr === 1'b1) found = 1;
      else @(negedge clk);
    end
    chk("wait_wr_seen", {7'd0, found}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr", {7'd0, wr}, 8'd0);
    chk("midrst_wrn", {4'd0, wrn}, 8'd0);
    chk("midrst_cnt", stall_cnt, 8'd0);
    chk("midrst_stall", {7'd0, stall}, 8'd0);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_wr", k), {7'd0, wr}, 8'd0);
      chk($sformatf("post_rst%0d_cnt", k), stall_cnt, 8'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
